d_cache_2way: RTL and testbench

D_CACHE_2WAY -- requirements
Module: d_cache_2way

---
 rtl/d_cache_2way_pkg.sv | 22 ++
 rtl/d_cache_way.sv | 63 ++++++
 rtl/d_cache_2way.sv | 174 +++++++++++++++++
 tb/tb_d_cache_2way.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_2way_pkg.sv
// Shared types and constants for the 2-way write-back data cache.
// Holds the FSM encoding, uncached-region masks and default geometry.
package d_cache_2way_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_UNC
  } state_t;

  localparam logic [2:0] UNC_HI3 = 3'b101;
  localparam logic [3:0] UNC_HI4 = 4'b1000;

  localparam int C_INDEX_DEF = 6;
  localparam int L_WORDS_DEF = 4;

  function automatic logic is_unc(input logic [3:0] hi);
    return (hi[3:1] == UNC_HI3) || (hi == UNC_HI4);
  endfunction

endpackage

// File: rtl/d_cache_way.sv
// One cache way: valid/dirty bits, tags and byte-writable line data.
// Reads are combinational; writes land on the clock edge.
module d_cache_way
  import d_cache_2way_pkg::*;
#(
  parameter int C_INDEX = C_INDEX_DEF,
  parameter int L_WORDS = L_WORDS_DEF,
  parameter int T_WIDTH = 22,
  localparam int OW = $clog2(L_WORDS),
  localparam int SETS = 1 << C_INDEX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_INDEX-1:0] idx,
  input  logic [OW-1:0]      off,
  input  logic [3:0]         we,
  input  logic [31:0]        wdata,
  input  logic               set_dirty,
  input  logic               fill_done,
  input  logic [T_WIDTH-1:0] fill_tag,
  output logic [T_WIDTH-1:0] tag,
  output logic               valid,
  output logic               dirty,
  output logic [31:0]        rdata
);

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [T_WIDTH-1:0] tags [SETS];
  logic [31:0]        data [SETS*L_WORDS];

  logic [C_INDEX+OW-1:0] addr;

  assign addr  = {idx, off};
  assign tag   = tags[idx];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign rdata = data[addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (set_dirty)
        dirty_q[idx] <= 1'b1;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tags and data carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_done)
      tags[idx] <= fill_tag;
    for (int b = 0; b < 4; b++)
      if (we[b])
        data[addr][8*b +: 8] <= wdata[8*b +: 8];
  end

endmodule

// File: rtl/d_cache_2way.sv
// 2-way set-associative write-back, write-allocate data cache with
// an uncached pass-through window.
module d_cache_2way
  import d_cache_2way_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int C_INDEX = C_INDEX_DEF,
  parameter int L_WORDS = L_WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic [31:0]        p_dout,
  output logic [31:0]        p_din,
  input  logic               p_strobe,
  input  logic [3:0]         p_wen,
  input  logic [1:0]         p_size,
  input  logic               p_rw,
  output logic               p_ready,
  output logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_dout,
  output logic [31:0]        m_din,
  output logic               m_strobe,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  output logic               m_rw,
  input  logic               m_ready
);

  localparam int OW = $clog2(L_WORDS);
  localparam int TW = A_WIDTH - C_INDEX - OW - 2;
  localparam int SETS = 1 << C_INDEX;
  localparam logic [OW-1:0] LAST = OW'(L_WORDS - 1);

  state_t             state;
  logic [OW-1:0]      cnt;
  logic               victim;
  logic [C_INDEX-1:0] idx_l;
  logic [TW-1:0]      tag_l;
  logic [SETS-1:0]    lru;

  logic [C_INDEX-1:0] idx_p, idx;
  logic [OW-1:0]      off_p, off;
  logic [TW-1:0]      tag_p, tag0, tag1;
  logic               v0, v1, d0, d1;
  logic [31:0]        rd0, rd1, wdata;
  logic               idle, unc, req_c, hit0, hit1, hit, miss;
  logic               vic_n, vic_dirty, last, fill_we, wr_hit;
  logic [3:0]         we0, we1;

  assign idx_p = p_a[OW+2 +: C_INDEX];
  assign off_p = p_a[2 +: OW];
  assign tag_p = p_a[A_WIDTH-1 -: TW];
  assign unc   = is_unc(p_a[31:28]);
  assign idle  = (state == S_IDLE);
  assign idx   = idle ? idx_p : idx_l;
  assign off   = idle ? off_p : cnt;
  assign wdata = idle ? p_dout : m_dout;
  assign last  = (cnt == LAST);

  assign hit0  = v0 && (tag0 == tag_p);
  assign hit1  = v1 && (tag1 == tag_p);
  assign req_c = idle && p_strobe && !rst && !unc;
  assign hit   = req_c && (hit0 || hit1);
  assign miss  = req_c && !(hit0 || hit1);

  // Fill invalid ways first (way 0 wins), then evict by LRU.
  assign vic_n     = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[idx_p]);
  assign vic_dirty = vic_n ? (v1 && d1) : (v0 && d0);

  assign wr_hit  = hit && p_rw;
  assign fill_we = (state == S_FILL) && m_ready;
  assign we0 = (wr_hit && hit0) ? p_wen :
               (fill_we && !victim) ? 4'hF : 4'h0;
  assign we1 = (wr_hit && !hit0) ? p_wen :
               (fill_we && victim) ? 4'hF : 4'h0;

  d_cache_way #(
    .C_INDEX(C_INDEX), .L_WORDS(L_WORDS), .T_WIDTH(TW)
  ) u_way0 (
    .clk(clk), .rst(rst), .idx(idx), .off(off),
    .we(we0), .wdata(wdata),
    .set_dirty(wr_hit && hit0),
    .fill_done(fill_we && last && !victim),
    .fill_tag(tag_l),
    .tag(tag0), .valid(v0), .dirty(d0), .rdata(rd0)
  );

  d_cache_way #(
    .C_INDEX(C_INDEX), .L_WORDS(L_WORDS), .T_WIDTH(TW)
  ) u_way1 (
    .clk(clk), .rst(rst), .idx(idx), .off(off),
    .we(we1), .wdata(wdata),
    .set_dirty(wr_hit && !hit0),
    .fill_done(fill_we && last && victim),
    .fill_tag(tag_l),
    .tag(tag1), .valid(v1), .dirty(d1), .rdata(rd1)
  );

  assign p_din   = (state == S_UNC) ? m_dout : (hit0 ? rd0 : rd1);
  assign p_ready = (state == S_UNC) ? m_ready : hit;

  always_comb begin
    m_a      = '0;
    m_din    = '0;
    m_strobe = 1'b0;
    m_wen    = 4'h0;
    m_size   = 2'b00;
    m_rw     = 1'b0;
    unique case (state)
      S_WB: begin
        m_a      = {victim ? tag1 : tag0, idx_l, cnt, 2'b00};
        m_din    = victim ? rd1 : rd0;
        m_strobe = 1'b1;
        m_wen    = 4'hF;
        m_size   = 2'b10;
        m_rw     = 1'b1;
      end
      S_FILL: begin
        m_a      = {tag_l, idx_l, cnt, 2'b00};
        m_strobe = 1'b1;
        m_wen    = 4'hF;
        m_size   = 2'b10;
      end
      S_UNC: begin
        m_a      = {3'b000, p_a[A_WIDTH-4:0]};
        m_din    = p_dout;
        m_strobe = 1'b1;
        m_wen    = p_wen;
        m_size   = p_size;
        m_rw     = p_rw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      lru    <= '0;
      victim <= 1'b0;
      idx_l  <= '0;
      tag_l  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (hit)
            lru[idx_p] <= hit0;
          if (miss) begin
            victim <= vic_n;
            idx_l  <= idx_p;
            tag_l  <= tag_p;
            cnt    <= '0;
            state  <= vic_dirty ? S_WB : S_FILL;
          end else if (p_strobe && unc) begin
            state <= S_UNC;
          end
        end
        S_WB: if (m_ready) begin
          cnt <= cnt + 1'b1;
          if (last) state <= S_FILL;
        end
        S_FILL: if (m_ready) begin
          cnt <= cnt + 1'b1;
          if (last) state <= S_IDLE;
        end
        S_UNC: if (m_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_2way.sv
// Directed bench for d_cache_2way with a behavioural word memory.
// The memory answers each strobe after an optional random stall.
module tb_d_cache_2way;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] p_a = '0;
  logic [31:0] p_dout = '0;
  logic [31:0] p_din;
  logic        p_strobe = 1'b0;
  logic [3:0]  p_wen = '0;
  logic [1:0]  p_size = 2'b10;
  logic        p_rw = 1'b0;
  logic        p_ready;
  logic [31:0] m_a;
  logic [31:0] m_dout = '0;
  logic [31:0] m_din;
  logic        m_strobe;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;
  logic        m_rw;
  logic        m_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int bad_rdy = 0;
  int stall = 0;
  bit stall_en = 1'b0;
  bit unc_mode = 1'b0;

  logic [31:0] wmem [logic [29:0]];
  logic [32:0] trace [$];

  d_cache_2way dut (
    .clk(clk), .rst(rst),
    .p_a(p_a), .p_dout(p_dout), .p_din(p_din),
    .p_strobe(p_strobe), .p_wen(p_wen), .p_size(p_size),
    .p_rw(p_rw), .p_ready(p_ready),
    .m_a(m_a), .m_dout(m_dout), .m_din(m_din),
    .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size),
    .m_rw(m_rw), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (wmem.exists(a[31:2])) return wmem[a[31:2]];
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory responder: one ready pulse per word.
  always @(negedge clk) begin
    if (m_ready) begin
      m_ready = 1'b0;
      stall = stall_en ? int'($urandom_range(5, 0)) : 0;
    end else if (m_strobe) begin
      if (stall > 0) stall--;
      else begin
        m_ready = 1'b1;
        m_dout = rd_mem(m_a);
      end
    end
  end

  always @(posedge clk) begin
    logic [31:0] t;
    if (m_strobe && m_ready) begin
      trace.push_back({m_rw, m_a});
      if (m_rw) begin
        t = rd_mem(m_a);
        for (int b = 0; b < 4; b++)
          if (m_wen[b]) t[8*b +: 8] = m_din[8*b +: 8];
        wmem[m_a[31:2]] = t;
      end
    end
    if (m_strobe && p_ready && !unc_mode) bad_rdy++;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input bit rw,
                        input logic [3:0] wen, input logic [31:0] d,
                        output logic [31:0] q, output int cyc,
                        output logic [32:0] mx);
    p_a = a; p_rw = rw; p_wen = wen; p_dout = d;
    p_size = 2'b10; p_strobe = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (p_ready) break;
      if (cyc >= 400) begin cyc = -1; break; end
    end
    q = p_din;
    mx = {m_rw, m_a};
    @(posedge clk); #1;
    p_strobe = 1'b0; p_rw = 1'b0; p_wen = 4'h0;
  endtask

  task automatic chk_burst(input string tag, input int start,
                           input bit rw, input logic [31:0] base);
    for (int w = 0; w < 4; w++)
      check(tag, (start + w < trace.size()) ? trace[start + w] : 33'h0,
            {rw, base + 32'(4 * w)});
  endtask

  initial begin
    logic [31:0] q;
    logic [32:0] mx;
    int cyc;
    int k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_p_ready", p_ready, 1'b0);
    check("rst_m_strobe", m_strobe, 1'b0);
    check("rst_m_rw", m_rw, 1'b0);
    rst = 1'b0;

    trace.delete();
    access(32'h40, 0, 4'h0, 0, q, cyc, mx);
    check("cold_done", cyc > 0, 1'b1);
    check("cold_data", q, 32'hC0DE_0040);
    check("cold_len", trace.size(), 4);
    chk_burst("cold_fill", 0, 0, 32'h40);

    trace.delete();
    access(32'h44, 0, 4'h0, 0, q, cyc, mx);
    check("hit_cyc", cyc, 1);
    check("hit_data", q, 32'hC0DE_0044);

    access(32'h48, 1, 4'b0011, 32'hAABB_CCDD, q, cyc, mx);
    check("st_cyc", cyc, 1);
    access(32'h48, 0, 4'h0, 0, q, cyc, mx);
    check("st_merge", q, 32'hC0DE_CCDD);
    check("st_no_mem", trace.size(), 0);

    access(32'h440, 0, 4'h0, 0, q, cyc, mx);
    check("b_data", q, 32'hC0DE_0440);
    check("b_len", trace.size(), 4);
    trace.delete();
    access(32'h840, 0, 4'h0, 0, q, cyc, mx);
    check("c_data", q, 32'hC0DE_0840);
    check("c_len", trace.size(), 8);
    chk_burst("c_wb", 0, 1, 32'h40);
    chk_burst("c_fill", 4, 0, 32'h840);
    check("c_wb_mem", rd_mem(32'h48), 32'hC0DE_CCDD);
    trace.delete();
    access(32'h444, 0, 4'h0, 0, q, cyc, mx);
    check("b_kept_cyc", cyc, 1);
    check("b_kept_data", q, 32'hC0DE_0444);
    access(32'h48, 0, 4'h0, 0, q, cyc, mx);
    check("a_back", q, 32'hC0DE_CCDD);
    check("a_clean_len", trace.size(), 4);
    chk_burst("a_refill", 0, 0, 32'h40);

    unc_mode = 1'b1;
    trace.delete();
    access(32'hA000_0010, 0, 4'h0, 0, q, cyc, mx);
    check("unc_rd_addr", mx, {1'b0, 32'h10});
    check("unc_rd_data", q, 32'hC0DE_0010);
    access(32'h8000_0020, 1, 4'hF, 32'h1234_5678, q, cyc, mx);
    check("unc_wr_addr", mx, {1'b1, 32'h20});
    check("unc_wr_mem", rd_mem(32'h20), 32'h1234_5678);
    check("unc_len", trace.size(), 2);
    unc_mode = 1'b0;
    access(32'h444, 0, 4'h0, 0, q, cyc, mx);
    check("unc_keep_cyc", cyc, 1);
    check("unc_keep_data", q, 32'hC0DE_0444);

    trace.delete();
    p_a = 32'h1040; p_rw = 1'b0; p_strobe = 1'b1;
    k = 0;
    while (trace.size() < 1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("rf_word0", trace.size(), 1);
    p_strobe = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rf_m_strobe", m_strobe, 1'b0);
    check("rf_p_ready", p_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    trace.delete();
    access(32'h1040, 0, 4'h0, 0, q, cyc, mx);
    check("rf_len", trace.size(), 4);
    chk_burst("rf_refill", 0, 0, 32'h1040);
    check("rf_data", q, 32'hC0DE_1040);

    stall_en = 1'b1;
    access(32'h1044, 1, 4'hF, 32'h1111_2222, q, cyc, mx);
    check("sx_st_cyc", cyc, 1);
    access(32'h1440, 0, 4'h0, 0, q, cyc, mx);
    check("sx_b_data", q, 32'hC0DE_1440);
    trace.delete();
    access(32'h1840, 0, 4'h0, 0, q, cyc, mx);
    check("sx_done", cyc > 0, 1'b1);
    check("sx_len", trace.size(), 8);
    chk_burst("sx_wb", 0, 1, 32'h1040);
    chk_burst("sx_fill", 4, 0, 32'h1840);
    check("sx_data", q, 32'hC0DE_1840);
    check("sx_wb_mem", rd_mem(32'h1044), 32'h1111_2222);
    access(32'h1444, 0, 4'h0, 0, q, cyc, mx);
    check("sx_keep", q, 32'hC0DE_1444);
    access(32'h1044, 0, 4'h0, 0, q, cyc, mx);
    check("sx_back", q, 32'h1111_2222);

    check("no_rdy_in_xfer", bad_rdy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
